// File: rtl/l1_pkg.sv
// Shared widths, FSM state type and beat-address helper for the L1 refill sequencer.
package l1_pkg;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;
  localparam int BLK_W         = WORD_W * WORDS_PER_BLK;
  localparam int ADDR_W        = 32;
  localparam int OFFSET_W      = 4;
  localparam int BASE_W        = ADDR_W - OFFSET_W;
  localparam int BEAT_W        = $clog2(WORDS_PER_BLK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    FILL = 2'd3
  } state_e;

  // Word-aligned address of one beat inside a block.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [BASE_W-1:0] base,
                                                 input logic [BEAT_W-1:0] beat);
    return {base, beat, 2'b00};
  endfunction
endpackage

// File: rtl/l1_refill_ctrl.sv
// Miss/refill sequencer: optional 4-beat victim writeback, 4-beat block fetch,
// then a one-cycle fill strobe back to L1.
module l1_refill_ctrl #(
  parameter int WORD_W        = 32,
  parameter int WORDS_PER_BLK = 4,
  parameter int ADDR_W        = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            miss_req,
  input  logic [ADDR_W-1:0]               miss_addr,
  input  logic                            victim_dirty,
  input  logic [ADDR_W-1:0]               victim_addr,
  input  logic [WORD_W*WORDS_PER_BLK-1:0] victim_block,
  output logic                            busy,
  output logic                            fill_valid,
  output logic [ADDR_W-1:0]               fill_addr,
  output logic [WORD_W*WORDS_PER_BLK-1:0] fill_block,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [WORD_W-1:0]               mem_wdata,
  input  logic [WORD_W-1:0]               mem_rdata,
  input  logic                            mem_ack
);
  import l1_pkg::*;

  localparam int                BASE_BITS = ADDR_W - OFFSET_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BLK - 1);

  state_e               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [BASE_BITS-1:0] miss_base_q, miss_base_d;
  logic [BASE_BITS-1:0] vict_base_q, vict_base_d;
  logic [WORD_W-1:0]    vict_word_q [WORDS_PER_BLK];
  logic [WORD_W-1:0]    vict_word_d [WORDS_PER_BLK];
  logic [WORD_W-1:0]    fill_word_q [WORDS_PER_BLK];
  logic [WORD_W-1:0]    fill_word_d [WORDS_PER_BLK];
  logic                 beat_last;
  logic                 unused_offsets;

  // Byte/word offset bits of the incoming addresses never select anything.
  assign unused_offsets = ^{miss_addr[OFFSET_W-1:0], victim_addr[OFFSET_W-1:0]};
  assign beat_last      = (beat_q == LAST_BEAT);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    miss_base_d = miss_base_q;
    vict_base_d = vict_base_q;
    for (int i = 0; i < WORDS_PER_BLK; i++) begin
      vict_word_d[i] = vict_word_q[i];
      fill_word_d[i] = fill_word_q[i];
    end
    case (state_q)
      IDLE: begin
        if (miss_req) begin
          miss_base_d = miss_addr[ADDR_W-1:OFFSET_W];
          vict_base_d = victim_addr[ADDR_W-1:OFFSET_W];
          for (int i = 0; i < WORDS_PER_BLK; i++) begin
            vict_word_d[i] = victim_block[i*WORD_W +: WORD_W];
          end
          beat_d  = '0;
          state_d = victim_dirty ? WB : RD;
        end
      end
      WB: begin
        if (mem_ack) begin
          if (beat_last) begin
            beat_d  = '0;
            state_d = RD;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      RD: begin
        if (mem_ack) begin
          fill_word_d[beat_q] = mem_rdata;
          if (beat_last) begin
            beat_d  = '0;
            state_d = FILL;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      FILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      miss_base_q <= '0;
      vict_base_q <= '0;
      for (int i = 0; i < WORDS_PER_BLK; i++) begin
        vict_word_q[i] <= '0;
        fill_word_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      miss_base_q <= miss_base_d;
      vict_base_q <= vict_base_d;
      for (int i = 0; i < WORDS_PER_BLK; i++) begin
        vict_word_q[i] <= vict_word_d[i];
        fill_word_q[i] <= fill_word_d[i];
      end
    end
  end

  // Memory-side outputs decode straight from registered state, so reset kills them at once.
  assign busy       = (state_q != IDLE);
  assign fill_valid = (state_q == FILL);
  assign mem_req    = (state_q == WB) || (state_q == RD);
  assign mem_we     = (state_q == WB);
  assign mem_addr   = (state_q == WB) ? beat_addr(vict_base_q, beat_q) :
                      (state_q == RD) ? beat_addr(miss_base_q, beat_q) : '0;
  assign mem_wdata  = mem_we ? vict_word_q[beat_q] : '0;
  assign fill_addr  = fill_valid ? {miss_base_q, {OFFSET_W{1'b0}}} : '0;

  generate
    for (genvar gi = 0; gi < WORDS_PER_BLK; gi++) begin : g_fill_pack
      assign fill_block[gi*WORD_W +: WORD_W] = fill_word_q[gi];
    end
  endgenerate
endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Self-checking bench for l1_refill_ctrl: directed vector table, corner sequences,
// and randomized misses against a transaction-level reference model.
module tb_l1_refill_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         victim_dirty;
  logic [31:0]  victim_addr;
  logic [127:0] victim_block;
  logic         busy, fill_valid, mem_req, mem_we;
  logic [31:0]  fill_addr, mem_addr, mem_wdata;
  logic [127:0] fill_block;
  logic [31:0]  mem_rdata;
  logic         mem_ack;

  l1_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_block(victim_block),
    .busy(busy), .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_block(fill_block),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int       ack_mode = 0;   // 0 always ack, 1 random ack, 2 scripted read stall
  bit       rand_data = 0;
  logic [7:0] rbase = 8'h00;
  int       stall_beat = 0;
  int       stall_left = 0;
  int       rd_k = 0;        // index of the current read beat of the active miss

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      case (ack_mode)
        0: mem_ack = 1'b1;
        1: mem_ack = ($urandom_range(0, 3) != 0);
        default: begin
          if (mem_req && !mem_we && rd_k == stall_beat && stall_left > 0) begin
            mem_ack = 1'b0;
            stall_left--;
          end else begin
            mem_ack = 1'b1;
          end
        end
      endcase
      mem_rdata = rand_data ? $urandom : {24'h0, rbase + 8'(rd_k)};
    end
  end

  // ---------------- reference model / monitor ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  int           cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t        exp_q[$];
  bit           active = 0;
  bit           cur_dirty = 0;
  int           t0 = 0;
  int           stalls = 0;
  logic [31:0]  exp_fill_addr = '0;
  logic [127:0] exp_blk = '0;
  logic [127:0] exp_hold_blk = '0;
  bit           hold_valid = 0;
  logic         hold_we;
  logic [31:0]  hold_addr, hold_wdata;
  bit           first_pending = 0;
  int           fills = 0, accepts = 0, last_lat = 0;
  logic [31:0]  last_fill_addr = '0, last_first_addr = '0;
  logic [127:0] last_fill_blk = '0;

  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      active = 0; hold_valid = 0; exp_q.delete(); exp_hold_blk = '0; first_pending = 0;
    end else begin
      check("busy", busy, active);
      if (hold_valid) begin
        check("hold_req", mem_req, 1'b1);
        check("hold_addr", mem_addr, hold_addr);
        check("hold_we", mem_we, hold_we);
        check("hold_wdata", mem_wdata, hold_wdata);
      end
      hold_valid = mem_req && !mem_ack;
      hold_we = mem_we; hold_addr = mem_addr; hold_wdata = mem_wdata;

      if (active && mem_req) begin
        if (!mem_ack) begin
          stalls++;
        end else if (exp_q.size() == 0) begin
          check("extra_beat", 1'b1, 1'b0);
        end else begin
          b = exp_q.pop_front();
          if (first_pending) begin last_first_addr = mem_addr; first_pending = 0; end
          check("beat_we", mem_we, b.we);
          check("beat_addr", mem_addr, b.addr);
          if (b.we) check("beat_wdata", mem_wdata, b.wdata);
          else begin
            exp_blk[32*rd_k +: 32] = mem_rdata;
            rd_k++;
          end
        end
      end

      if (active && fill_valid) begin
        check("fill_beats_left", exp_q.size(), 0);
        check("fill_addr", fill_addr, exp_fill_addr);
        check("fill_block", fill_block, exp_blk);
        last_lat = cyc + 1 - t0;
        check("fill_latency", last_lat, (cur_dirty ? 9 : 5) + stalls);
        last_fill_addr = fill_addr; last_fill_blk = fill_block;
        exp_hold_blk = exp_blk;
        fills++;
        active = 0;
      end else if (!active) begin
        check("idle_mem_req", mem_req, 1'b0);
        check("idle_fill_valid", fill_valid, 1'b0);
        check("fill_block_hold", fill_block, exp_hold_blk);
        if (miss_req) begin
          // accepted at the coming edge: build the expected beat list from the rules
          active = 1; accepts++; t0 = cyc + 1; stalls = 0; rd_k = 0;
          cur_dirty = victim_dirty; exp_blk = '0; first_pending = 1;
          exp_fill_addr = {miss_addr[31:4], 4'h0};
          if (victim_dirty)
            for (int i = 0; i < 4; i++)
              exp_q.push_back('{1'b1, {victim_addr[31:4], 4'(i * 4)}, victim_block[32*i +: 32]});
          for (int i = 0; i < 4; i++)
            exp_q.push_back('{1'b0, {miss_addr[31:4], 4'(i * 4)}, 32'h0});
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic start_miss(input logic [31:0] a, input logic d, input logic [31:0] va,
                            input logic [127:0] vb);
    int a0;
    int n;
    @(posedge clk); #1;
    a0 = accepts;
    miss_addr = a; victim_dirty = d; victim_addr = va; victim_block = vb; miss_req = 1'b1;
    n = 0;
    while (accepts == a0 && n < 20) begin tick(); n++; end
    check("miss_accepted", accepts > a0, 1'b1);
    @(posedge clk); #1;
    // scramble inputs: only the values latched at acceptance may matter
    miss_req = 1'b0; miss_addr = $urandom; victim_dirty = 1'($urandom);
    victim_addr = $urandom; victim_block = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_fill(input int target, input int budget, input string name);
    int n = 0;
    while (fills < target && n < budget) begin tick(); n++; end
    check(name, fills >= target, 1'b1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0]  miss_addr;
    logic         dirty;
    logic [31:0]  vaddr;
    logic [127:0] vblk;
    logic [7:0]   rbase;
    int           stall_beat;
    int           stall_cnt;
    logic [31:0]  exp_fill_addr;
    logic [127:0] exp_blk;
    int           exp_lat;
    logic [31:0]  exp_first;
  } vec_t;

  vec_t vt[4];

  initial begin
    int f0, a0;
    rst = 1'b1; miss_req = 1'b0; miss_addr = '0; victim_dirty = 1'b0;
    victim_addr = '0; victim_block = '0;

    vt[0] = '{32'h0000_1234, 1'b0, 32'hDEAD_BEEF, 128'h55555555_66666666_77777777_88888888,
              8'hA0, 0, 0, 32'h0000_1230, 128'h000000A3_000000A2_000000A1_000000A0, 5, 32'h0000_1230};
    vt[1] = '{32'h0000_0040, 1'b1, 32'h0000_8000, 128'h44444444_33333333_22222222_11111111,
              8'h10, 0, 0, 32'h0000_0040, 128'h00000013_00000012_00000011_00000010, 9, 32'h0000_8000};
    vt[2] = '{32'h0000_1234, 1'b0, 32'h0000_0000, 128'h0,
              8'hB0, 1, 2, 32'h0000_1230, 128'h000000B3_000000B2_000000B1_000000B0, 7, 32'h0000_1230};
    vt[3] = '{32'hFFFF_FFFF, 1'b1, 32'h1234_567F, 128'h89ABCDEF_01234567_DEADBEEF_CAFEF00D,
              8'hF0, 3, 1, 32'hFFFF_FFF0, 128'h000000F3_000000F2_000000F1_000000F0, 10, 32'h1234_5670};

    #2 rst = 1'b0;
    #20;
    check("rst_busy", busy, 1'b0);
    check("rst_fill_valid", fill_valid, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_fill_addr", fill_addr, 32'h0);
    check("rst_fill_block", fill_block, 128'h0);
    @(posedge clk); #2 rst = 1'b1;

    // spurious acks while idle
    ack_mode = 0;
    repeat (5) begin
      tick();
      check("spur_mem_addr", mem_addr, 32'h0);
      check("spur_mem_we", mem_we, 1'b0);
      check("spur_busy", busy, 1'b0);
    end

    for (int i = 0; i < 4; i++) begin
      ack_mode = (vt[i].stall_cnt > 0) ? 2 : 0;
      stall_beat = vt[i].stall_beat; stall_left = vt[i].stall_cnt;
      rbase = vt[i].rbase; rand_data = 0;
      f0 = fills;
      start_miss(vt[i].miss_addr, vt[i].dirty, vt[i].vaddr, vt[i].vblk);
      wait_fill(f0 + 1, 100, $sformatf("vec%0d_fill_seen", i));
      check($sformatf("vec%0d_fill_addr", i), last_fill_addr, vt[i].exp_fill_addr);
      check($sformatf("vec%0d_fill_block", i), last_fill_blk, vt[i].exp_blk);
      check($sformatf("vec%0d_latency", i), last_lat, vt[i].exp_lat);
      check($sformatf("vec%0d_first_addr", i), last_first_addr, vt[i].exp_first);
    end

    // busy lockout, then acceptance in the cycle right after FILL
    ack_mode = 0; rbase = 8'hC0;
    f0 = fills; a0 = accepts;
    start_miss(32'h0000_1000, 1'b0, 32'h0, 128'h0);
    miss_addr = 32'h0000_2000; victim_dirty = 1'b0; miss_req = 1'b1;
    wait_fill(f0 + 1, 50, "lock_fill_seen");
    check("lock_no_accept", accepts, a0 + 1);
    check("lock_fill_addr", last_fill_addr, 32'h0000_1000);
    @(posedge clk); #1;
    tick();
    check("lock_reaccept", accepts, a0 + 2);
    @(posedge clk); #1;
    miss_req = 1'b0;
    check("lock_new_req", mem_req, 1'b1);
    check("lock_new_addr", mem_addr, 32'h0000_2000);
    wait_fill(f0 + 2, 50, "lock_fill2_seen");

    // randomized misses with random ack timing and random read data
    ack_mode = 1; rand_data = 1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      f0 = fills;
      start_miss($urandom, 1'($urandom), $urandom, {$urandom, $urandom, $urandom, $urandom});
      wait_fill(f0 + 1, 300, "rand_fill_seen");
    end

    // asynchronous reset in the middle of writeback beat 2
    ack_mode = 0; rand_data = 0;
    f0 = fills; a0 = accepts;
    start_miss(32'h0000_0040, 1'b1, 32'h0000_8000, 128'h44444444_33333333_22222222_11111111);
    begin
      int n = 0;
      while (!(mem_req && mem_we && mem_addr == 32'h0000_8008) && n < 20) begin
        @(negedge clk); n++;
      end
      check("rst_reach_wb2", mem_addr, 32'h0000_8008);
    end
    #2 rst = 1'b0;
    #1;
    check("arst_mem_req", mem_req, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_fill_valid", fill_valid, 1'b0);
    check("arst_mem_addr", mem_addr, 32'h0);
    check("arst_fill_block", fill_block, 128'h0);
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    repeat (8) tick();
    check("post_rst_no_accept", accepts, a0 + 1);
    check("post_rst_no_fill", fills, f0);
    check("post_rst_mem_req", mem_req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
